// File: rtl/seq_adder_sub.sv
// rtl/seq_adder_sub.sv - digit-serial adder/subtractor with start/done handshake
module seq_adder_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic             last_dig;

    // One DIGIT-wide ripple slice working on the digit selected by the counter
    always_comb begin
        a_dig    = a_q[cnt_q*DIGIT +: DIGIT];
        b_dig    = bx_q[cnt_q*DIGIT +: DIGIT];
        dsum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, c_q};
        last_dig = (cnt_q == CW'(N - 1));
    end

    // Next-state: accept in IDLE/DONE, step one digit per cycle in RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bx_d    = bx_q;
        s_d     = s_q;
        c_d     = c_q;
        co_d    = co_q;
        ov_d    = ov_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    // Subtraction as A + ~B + ~borrow_in reuses the adder slice
                    bx_d    = sub ? ~B : B;
                    c_d     = sub ? ~Cin : Cin;
                    cnt_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    ov_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
                c_d   = dsum[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (last_dig) begin
                    co_d    = dsum[DIGIT];
                    // Same-sign operands producing a different-sign result
                    ov_d    = (a_q[MSB] == bx_q[MSB]) && (s_d[MSB] != a_q[MSB]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            s_q     <= s_d;
            c_q     <= c_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign S         = s_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_seq_adder_sub.sv
// tb/tb_seq_adder_sub.sv - randomized and directed checks of seq_adder_sub against an arithmetic model
module tb_seq_adder_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    logic        sub_i;
    logic        cin_i;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  busy_v, done_v, co_v, ov_v;
    logic [7:0]  s0, s1, s2;
    logic [15:0] s3;

    int n_checks = 0;
    int n_pass   = 0;

    int wid[4] = '{8, 8, 8, 16};
    int nn[4]  = '{8, 4, 1, 4};

    logic [15:0] last_s[4];
    logic        last_co[4];
    logic        last_ov[4];

    always #5 clk = ~clk;

    seq_adder_sub #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_i), .A(a_in[7:0]), .B(b_in[7:0]),
        .Cin(cin_i), .busy(busy_v[0]), .done(done_v[0]), .S(s0), .carry_out(co_v[0]), .overflow(ov_v[0]));
    seq_adder_sub #(.WIDTH(8), .DIGIT(2)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_i), .A(a_in[7:0]), .B(b_in[7:0]),
        .Cin(cin_i), .busy(busy_v[1]), .done(done_v[1]), .S(s1), .carry_out(co_v[1]), .overflow(ov_v[1]));
    seq_adder_sub #(.WIDTH(8), .DIGIT(8)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_i), .A(a_in[7:0]), .B(b_in[7:0]),
        .Cin(cin_i), .busy(busy_v[2]), .done(done_v[2]), .S(s2), .carry_out(co_v[2]), .overflow(ov_v[2]));
    seq_adder_sub #(.WIDTH(16), .DIGIT(4)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub_i), .A(a_in), .B(b_in),
        .Cin(cin_i), .busy(busy_v[3]), .done(done_v[3]), .S(s3), .carry_out(co_v[3]), .overflow(ov_v[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] get_s(input int i);
        if (i == 0) return {8'h00, s0};
        if (i == 1) return {8'h00, s1};
        if (i == 2) return {8'h00, s2};
        return s3;
    endfunction

    // Plain integer arithmetic: wrapped result, unsigned carry/no-borrow, signed range overflow
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic c,
                                  output logic [15:0] r, output logic co, output logic ov);
        longint m, ua, ub, sa, sb, t, st, ci;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        ci = longint'(c);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!s) begin
            t  = ua + ub + ci;
            co = (t >= m);
            st = sa + sb + ci;
        end else begin
            t  = ua - ub - ci;
            co = (ua >= ub + ci);
            st = sa - sb - ci;
        end
        r  = 16'(((t % m) + m) % m);
        ov = (st < -(m / 2)) || (st >= m / 2);
    endfunction

    // Drives one start at the current negedge; returns at the negedge of the last done cycle
    task automatic run_op(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, input int mid_cyc);
        int last;
        a_in = a; b_in = b; sub_i = s; cin_i = c; start_v = mask;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                model(wid[i], a, b, s, c, last_s[i], last_co[i], last_ov[i]);
                if (nn[i] + 1 > last) last = nn[i] + 1;
            end
        end
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && cyc <= nn[i] + 1) begin
                    check($sformatf("d%0d busy c%0d", i, cyc), 32'(busy_v[i]), 32'(cyc <= nn[i]));
                    check($sformatf("d%0d done c%0d", i, cyc), 32'(done_v[i]), 32'(cyc == nn[i] + 1));
                    if (cyc == nn[i] + 1) begin
                        check($sformatf("d%0d S", i), 32'(get_s(i)), 32'(last_s[i]));
                        check($sformatf("d%0d carry", i), 32'(co_v[i]), 32'(last_co[i]));
                        check($sformatf("d%0d ovf", i), 32'(ov_v[i]), 32'(last_ov[i]));
                    end
                end
            end
            start_v = 4'b0000;
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
            sub_i = 1'($urandom);
            cin_i = 1'($urandom);
            if (cyc == mid_cyc) start_v = mask;
        end
    endtask

    // One cycle after done: back in IDLE with results still held
    task automatic idle_check(input logic [3:0] mask);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                check($sformatf("d%0d idle busy", i), 32'(busy_v[i]), 32'd0);
                check($sformatf("d%0d idle done", i), 32'(done_v[i]), 32'd0);
                check($sformatf("d%0d hold S", i), 32'(get_s(i)), 32'(last_s[i]));
                check($sformatf("d%0d hold carry", i), 32'(co_v[i]), 32'(last_co[i]));
                check($sformatf("d%0d hold ovf", i), 32'(ov_v[i]), 32'(last_ov[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_v = 4'b0000; sub_i = 1'b0; cin_i = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d rst busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("d%0d rst done", i), 32'(done_v[i]), 32'd0);
            check($sformatf("d%0d rst S", i), 32'(get_s(i)), 32'd0);
            check($sformatf("d%0d rst carry", i), 32'(co_v[i]), 32'd0);
            check($sformatf("d%0d rst ovf", i), 32'(ov_v[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_op(4'b0001, 16'h007F, 16'h0001, 1'b0, 1'b0, 0);
        check("plan 7F+01", 32'(s0), 32'h80);
        idle_check(4'b0001);
        run_op(4'b0001, 16'h00FF, 16'h0001, 1'b0, 1'b1, 0);
        idle_check(4'b0001);
        run_op(4'b0010, 16'h0005, 16'h0007, 1'b1, 1'b0, 0);
        check("plan 05-07", 32'(s1), 32'hFE);
        idle_check(4'b0010);
        run_op(4'b0010, 16'h0080, 16'h0001, 1'b1, 1'b0, 0);
        idle_check(4'b0010);
        run_op(4'b0100, 16'h0012, 16'h0034, 1'b0, 1'b0, 0);
        check("plan 12+34", 32'(s2), 32'h46);
        idle_check(4'b0100);

        // Start ignored mid-run, then back-to-back start in the done cycle
        run_op(4'b0001, 16'h003C, 16'h0021, 1'b0, 1'b0, 3);
        run_op(4'b0001, 16'h0055, 16'h00AA, 1'b1, 1'b1, 0);
        idle_check(4'b0001);

        // Reset after three RUN cycles aborts with no done pulse
        a_in = 16'h00FF; b_in = 16'h0000; sub_i = 1'b0; cin_i = 1'b0; start_v = 4'b0001;
        @(negedge clk);
        start_v = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy_v[0]), 32'd0);
        check("abort done", 32'(done_v[0]), 32'd0);
        check("abort S", 32'(s0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            check($sformatf("post-abort done c%0d", cyc), 32'(done_v[0]), 32'd0);
        end
        run_op(4'b0001, 16'h0033, 16'h0044, 1'b0, 1'b1, 0);
        idle_check(4'b0001);

        // Random operations on all four configurations at once
        for (int k = 0; k < 40; k++) begin
            run_op(4'b1111, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
            if (k % 8 == 7) idle_check(4'b1111);
        end
        idle_check(4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
